// File: rtl/spi_frame_collector.sv
// Passive SPI mode-0 sniffer: one packet per chip-select frame, pkt_valid SYNC_STAGES+2 cycles after CS rises.
// Single-entry output buffer; a commit while it is held and not accepted is dropped and marks overrun.
module spi_frame_collector #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        spi_clk,
  input  logic        spi_csn,
  input  logic        spi_sdo0,
  input  logic [5:0]  cfg_cmd_len,
  input  logic [5:0]  cfg_addr_len,
  input  logic [15:0] cfg_dummy_len,
  input  logic [5:0]  cfg_data_len,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [31:0] pkt_cmd,
  output logic [31:0] pkt_addr,
  output logic [31:0] pkt_data,
  output logic [15:0] pkt_bit_count,
  output logic [2:0]  pkt_flag
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_TAIL, S_WAIT_CS
  } state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, csn_sync_q, sdo_sync_q;
  logic clk_p_q, csn_p_q;
  logic clk_rise_q, csn_rise_q, csn_fall_q, sdo_q;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, bits_q, bits_d;
  logic [31:0] cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
  logic        long_q, long_d;
  logic [5:0]  cmd_len_q, cmd_len_d, addr_len_q, addr_len_d, data_len_q, data_len_d;
  logic [15:0] dummy_len_q, dummy_len_d;

  logic        valid_q, valid_d;
  logic [31:0] out_cmd_q, out_cmd_d, out_addr_q, out_addr_d, out_data_q, out_data_d;
  logic [15:0] out_bits_q, out_bits_d;
  logic [2:0]  out_flag_q, out_flag_d;

  logic        commit;
  logic [15:0] cur_len;

  // Next nonzero phase after 'from'; TAIL once every configured phase is exhausted.
  function automatic state_e next_phase(input state_e from, input logic [5:0] cl,
                                        input logic [5:0] al, input logic [15:0] dl,
                                        input logic [5:0] tl);
    next_phase = S_TAIL;
    if (from == S_IDLE && cl != 6'd0)
      next_phase = S_CMD;
    else if ((from == S_IDLE || from == S_CMD) && al != 6'd0)
      next_phase = S_ADDR;
    else if ((from == S_IDLE || from == S_CMD || from == S_ADDR) && dl != 16'd0)
      next_phase = S_DUMMY;
    else if (from != S_DATA && from != S_TAIL && tl != 6'd0)
      next_phase = S_DATA;
  endfunction

  always_comb begin
    cur_len = 16'd0;
    case (state_q)
      S_CMD:   cur_len = {10'd0, cmd_len_q};
      S_ADDR:  cur_len = {10'd0, addr_len_q};
      S_DUMMY: cur_len = dummy_len_q;
      S_DATA:  cur_len = {10'd0, data_len_q};
      default: cur_len = 16'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_d      = bits_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    long_d      = long_q;
    cmd_len_d   = cmd_len_q;
    addr_len_d  = addr_len_q;
    dummy_len_d = dummy_len_q;
    data_len_d  = data_len_q;
    commit      = 1'b0;
    case (state_q)
      S_WAIT_CS: if (csn_p_q) state_d = S_IDLE;
      S_IDLE: begin
        if (csn_fall_q) begin
          cmd_len_d   = cfg_cmd_len;
          addr_len_d  = cfg_addr_len;
          dummy_len_d = cfg_dummy_len;
          data_len_d  = cfg_data_len;
          cnt_d       = 16'd0;
          bits_d      = 16'd0;
          cmd_d       = 32'd0;
          addr_d      = 32'd0;
          data_d      = 32'd0;
          long_d      = 1'b0;
          state_d     = next_phase(S_IDLE, cfg_cmd_len, cfg_addr_len, cfg_dummy_len, cfg_data_len);
        end
      end
      default: begin
        if (csn_rise_q) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end else if (clk_rise_q) begin
          if (bits_q != 16'hFFFF) bits_d = bits_q + 16'd1;
          case (state_q)
            S_CMD:   cmd_d  = {cmd_q[30:0], sdo_q};
            S_ADDR:  addr_d = {addr_q[30:0], sdo_q};
            S_DATA:  data_d = {data_q[30:0], sdo_q};
            S_TAIL:  long_d = 1'b1;
            default: ;
          endcase
          if (state_q != S_TAIL) begin
            if (cnt_q == cur_len - 16'd1) begin
              cnt_d   = 16'd0;
              state_d = next_phase(state_q, cmd_len_q, addr_len_q, dummy_len_q, data_len_q);
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
      end
    endcase
  end

  // Output buffer: a held, unaccepted packet wins over a new commit.
  always_comb begin
    valid_d    = valid_q;
    out_cmd_d  = out_cmd_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_bits_d = out_bits_q;
    out_flag_d = out_flag_q;
    if (commit && valid_q && !pkt_ready) begin
      out_flag_d[2] = 1'b1;
    end else if (commit) begin
      valid_d    = 1'b1;
      out_cmd_d  = cmd_q;
      out_addr_d = addr_q;
      out_data_d = data_q;
      out_bits_d = bits_q;
      out_flag_d = {1'b0, long_q, state_q != S_TAIL};
    end else if (valid_q && pkt_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      clk_sync_q  <= '0;
      csn_sync_q  <= '0;
      sdo_sync_q  <= '0;
      clk_p_q     <= 1'b0;
      csn_p_q     <= 1'b0;
      clk_rise_q  <= 1'b0;
      csn_rise_q  <= 1'b0;
      csn_fall_q  <= 1'b0;
      sdo_q       <= 1'b0;
      state_q     <= S_WAIT_CS;
      cnt_q       <= 16'd0;
      bits_q      <= 16'd0;
      cmd_q       <= 32'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      long_q      <= 1'b0;
      cmd_len_q   <= 6'd0;
      addr_len_q  <= 6'd0;
      dummy_len_q <= 16'd0;
      data_len_q  <= 6'd0;
      valid_q     <= 1'b0;
      out_cmd_q   <= 32'd0;
      out_addr_q  <= 32'd0;
      out_data_q  <= 32'd0;
      out_bits_q  <= 16'd0;
      out_flag_q  <= 3'd0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      sdo_sync_q  <= {sdo_sync_q[SYNC_STAGES-2:0], spi_sdo0};
      clk_p_q     <= clk_sync_q[SYNC_STAGES-1];
      csn_p_q     <= csn_sync_q[SYNC_STAGES-1];
      clk_rise_q  <= clk_sync_q[SYNC_STAGES-1] & ~clk_p_q;
      csn_rise_q  <= csn_sync_q[SYNC_STAGES-1] & ~csn_p_q;
      csn_fall_q  <= ~csn_sync_q[SYNC_STAGES-1] & csn_p_q;
      sdo_q       <= sdo_sync_q[SYNC_STAGES-1];
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      long_q      <= long_d;
      cmd_len_q   <= cmd_len_d;
      addr_len_q  <= addr_len_d;
      dummy_len_q <= dummy_len_d;
      data_len_q  <= data_len_d;
      valid_q     <= valid_d;
      out_cmd_q   <= out_cmd_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_bits_q  <= out_bits_d;
      out_flag_q  <= out_flag_d;
    end
  end

  assign pkt_valid     = valid_q;
  assign pkt_cmd       = out_cmd_q;
  assign pkt_addr      = out_addr_q;
  assign pkt_data      = out_data_q;
  assign pkt_bit_count = out_bits_q;
  assign pkt_flag      = out_flag_q;

endmodule

// File: tb/tb_spi_frame_collector.sv
// Scoreboard bench for spi_frame_collector: directed frames push expected packets, a monitor pops on handshake.
module tb_spi_frame_collector;
  localparam int SYNC = 2;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_sdo0 = 1'b0;
  logic [5:0]  cfg_cmd_len = 6'd8;
  logic [5:0]  cfg_addr_len = 6'd24;
  logic [15:0] cfg_dummy_len = 16'd0;
  logic [5:0]  cfg_data_len = 6'd32;
  logic        pkt_valid;
  logic        pkt_ready = 1'b1;
  logic [31:0] pkt_cmd, pkt_addr, pkt_data;
  logic [15:0] pkt_bit_count;
  logic [2:0]  pkt_flag;

  typedef struct packed {
    logic [31:0] cmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] cnt;
    logic [2:0]  flag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  spi_frame_collector #(.SYNC_STAGES(SYNC)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_sdo0(spi_sdo0),
    .cfg_cmd_len(cfg_cmd_len), .cfg_addr_len(cfg_addr_len),
    .cfg_dummy_len(cfg_dummy_len), .cfg_data_len(cfg_data_len),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_cmd(pkt_cmd), .pkt_addr(pkt_addr), .pkt_data(pkt_data),
    .pkt_bit_count(pkt_bit_count), .pkt_flag(pkt_flag)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d,
                      input logic [15:0] n, input logic [2:0] f);
    exp_t e;
    e.cmd = c; e.addr = a; e.data = d; e.cnt = n; e.flag = f;
    exp_q.push_back(e);
  endtask

  task automatic spi_bit(input logic b);
    @(negedge HCLK) spi_sdo0 = b;
    repeat (4) @(negedge HCLK);
    spi_clk = 1'b1;
    repeat (4) @(negedge HCLK);
    spi_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) spi_bit(v[n-1-i]);
  endtask

  // Full frame; with measure set, the CS-rise to pkt_valid latency is checked.
  task automatic send_frame(input logic [127:0] v, input int n, input bit measure);
    int lat;
    @(negedge HCLK) spi_csn = 1'b0;
    repeat (4) @(negedge HCLK);
    send_bits(v, n);
    repeat (4) @(negedge HCLK);
    spi_csn = 1'b1;
    if (measure) begin
      lat = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge HCLK);
        lat++;
        #1;
        if (pkt_valid) break;
      end
      chk("latency", lat, SYNC + 2);
    end
    repeat (10) @(negedge HCLK);
  endtask

  always @(negedge HCLK) begin
    if (HRESETn && pkt_valid && pkt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pkt: got cmd %h cnt %0d flag %b required no packet",
                 pkt_cmd, pkt_bit_count, pkt_flag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pkt_cmd", pkt_cmd, e.cmd);
        chk("pkt_addr", pkt_addr, e.addr);
        chk("pkt_data", pkt_data, e.data);
        chk("pkt_bit_count", {16'd0, pkt_bit_count}, {16'd0, e.cnt});
        chk("pkt_flag", {29'd0, pkt_flag}, {29'd0, e.flag});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (5) @(negedge HCLK);
    chk("rst_valid", {31'd0, pkt_valid}, 32'd0);
    chk("rst_cmd", pkt_cmd, 32'd0);
    chk("rst_addr", pkt_addr, 32'd0);
    chk("rst_data", pkt_data, 32'd0);
    chk("rst_bits", {16'd0, pkt_bit_count}, 32'd0);
    chk("rst_flag", {29'd0, pkt_flag}, 32'd0);
    HRESETn = 1'b1;
    repeat (10) @(negedge HCLK);

    // Standard 8/24/0/32 frame
    push(32'h0B, 32'h123456, 32'hDEADBEEF, 16'd64, 3'b000);
    send_frame({8'h0B, 24'h123456, 32'hDEADBEEF}, 64, 1'b1);

    // Dummy phase, address skipped
    cfg_addr_len = 6'd0; cfg_dummy_len = 16'd8; cfg_data_len = 6'd16;
    push(32'h9F, 32'h0, 32'hA5C3, 16'd32, 3'b000);
    send_frame({8'h9F, 8'h5A, 16'hA5C3}, 32, 1'b0);

    // Short then long frame
    cfg_addr_len = 6'd24; cfg_dummy_len = 16'd0; cfg_data_len = 6'd32;
    push(32'h0B, 32'hABC, 32'h0, 16'd20, 3'b001);
    send_frame({8'h0B, 12'hABC}, 20, 1'b0);
    push(32'h0B, 32'h123456, 32'hDEADBEEF, 16'd70, 3'b010);
    send_frame({8'h0B, 24'h123456, 32'hDEADBEEF, 6'h2A}, 70, 1'b0);

    // Backpressure across two frames: second dropped, overrun on the first
    pkt_ready = 1'b0;
    push(32'hA1, 32'h000102, 32'h0A0B0C0D, 16'd64, 3'b100);
    send_frame({8'hA1, 24'h000102, 32'h0A0B0C0D}, 64, 1'b0);
    send_frame({8'hB2, 24'hFFFFFF, 32'h11111111}, 64, 1'b0);
    chk("held_valid", {31'd0, pkt_valid}, 32'd1);
    chk("held_cmd", pkt_cmd, 32'hA1);
    chk("held_flag", {29'd0, pkt_flag}, 32'd4);
    pkt_ready = 1'b1;
    repeat (30) @(negedge HCLK);

    // Reset mid-address, then CS stays low for 10 more edges: no packet
    @(negedge HCLK) spi_csn = 1'b0;
    repeat (4) @(negedge HCLK);
    send_bits({8'h0B, 10'h2AA}, 18);
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    chk("midrst_valid", {31'd0, pkt_valid}, 32'd0);
    HRESETn = 1'b1;
    send_bits({10'h3FF}, 10);
    repeat (4) @(negedge HCLK);
    spi_csn = 1'b1;
    repeat (20) @(negedge HCLK);
    push(32'h3C, 32'hC0FFEE, 32'h01234567, 16'd64, 3'b000);
    send_frame({8'h3C, 24'hC0FFEE, 32'h01234567}, 64, 1'b0);

    // Mid-frame configuration change is ignored
    push(32'h0B, 32'h123456, 32'hDEADBEEF, 16'd64, 3'b000);
    fork
      send_frame({8'h0B, 24'h123456, 32'hDEADBEEF}, 64, 1'b0);
      begin
        repeat (30) @(negedge HCLK);
        cfg_cmd_len = 6'd16;
      end
    join

    // All lengths zero: everything lands in TAIL
    cfg_cmd_len = 6'd0; cfg_addr_len = 6'd0; cfg_dummy_len = 16'd0; cfg_data_len = 6'd0;
    push(32'h0, 32'h0, 32'h0, 16'd5, 3'b010);
    send_frame({5'b10110}, 5, 1'b0);

    repeat (30) @(negedge HCLK);
    chk("leftover_expected", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_frame_collector.md
# spi_frame_collector

Captures serial frames driven by the SPI master onto its pad outputs (chip select, serial clock, data 0) and assembles each chip-select-bounded frame into one parallel packet of command, address and write-data fields plus a total bit count and error flags. It sits directly downstream of the SPI master's pad interface as a passive sniffer and feeds the subsystem's checking logic through a valid/ready packet port. All inputs from the SPI pins are asynchronous to the system clock.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the synchronizer on spi_clk, spi_csn and spi_sdo0 (minimum 2)
- HCLK  in  1  system clock; all logic on rising edge
- HRESETn  in  1  reset, synchronous, active-low
- spi_clk  in  1  SPI serial clock from master (async)
- spi_csn  in  1  SPI chip select, active-low (async)
- spi_sdo0  in  1  master data out (MOSI) (async)
- cfg_cmd_len  in  6  command bits per frame, 0..32
- cfg_addr_len  in  6  address bits per frame, 0..32
- cfg_dummy_len  in  16  dummy bits between address and data, 0..65535
- cfg_data_len  in  6  write-data bits per frame, 0..32
- pkt_valid  out  1  packet available
- pkt_ready  in  1  consumer accepts packet
- pkt_cmd  out  32  command field, right-aligned
- pkt_addr  out  32  address field, right-aligned
- pkt_data  out  32  data field, right-aligned
- pkt_bit_count  out  16  total spi_clk rising edges seen in frame, saturating at 65535
- pkt_flag  out  3  [0] short frame, [1] long frame, [2] overrun

## Operation
- Inputs pass through SYNC_STAGES flops; one further register gives edge detect on synchronized spi_clk and spi_csn.
- Sample: synchronized spi_sdo0 on each synchronized spi_clk rising edge while synchronized spi_csn is low (SPI mode 0).
- Frame start: synchronized spi_csn falling edge; cfg_* latched here, changes mid-frame ignored; shift registers and bit counter cleared.
- State machine: IDLE, CMD, ADDR, DUMMY, DATA, TAIL, WAIT_CS.
  - IDLE -> first nonzero phase among CMD, ADDR, DUMMY, DATA on frame start; all lengths zero -> TAIL.
  - Each phase counts sampled bits; on its last bit moves to next nonzero phase, else TAIL.
  - CMD/ADDR/DATA shift MSB-first: field <= {field[30:0], bit}. DUMMY discards bits.
  - TAIL: further edges counted, set long flag.
  - Any state on spi_csn rising edge -> IDLE and packet commit; short flag set if state is not TAIL (configured bits incomplete).
  - WAIT_CS: entered after reset; leaves to IDLE only when synchronized spi_csn is high, so no partial frame is ever captured.
- spi_csn rising edge in IDLE (no falling edge seen) produces no packet.
- Output: single-entry buffer. Commit loads pkt_* and sets pkt_valid. pkt_* hold while pkt_valid && !pkt_ready. Handshake completes on pkt_valid && pkt_ready.
- Commit while buffer full and not being accepted that cycle: new packet dropped, held packet's pkt_flag[2] set (sticky until accepted). Commit in the same cycle as acceptance: new packet loaded, no overrun.
- pkt_bit_count saturates at 65535, no wrap.

## Timing
- Reset: pkt_valid 0, pkt_cmd/addr/data 0, pkt_bit_count 0, pkt_flag 0, state WAIT_CS, synchronizers 0.
- Latency: spi_csn pin rising edge to pkt_valid high = SYNC_STAGES + 2 HCLK cycles.
- spi_clk high and low phases each at least 2 HCLK periods; spi_csn high time at least 3 HCLK periods. Faster input is outside spec.
- pkt_valid drops the cycle after acceptance unless a commit lands in that cycle.
- Reset mid-frame: frame discarded, pending packet discarded, WAIT_CS.

## Test plan
- cmd 8, addr 24, dummy 0, data 32, frame 0x0B, 0x123456, 0xDEADBEEF -> one packet cmd 0x0B, addr 0x123456, data 0xDEADBEEF, bit_count 64, flag 0, valid after SYNC_STAGES+2 cycles.
- cmd 8, addr 0, dummy 8, data 16, frame 0x9F, 8 junk bits, 0xA5C3 -> cmd 0x9F, addr 0, data 0xA5C3, bit_count 32, flag 0 (ADDR skipped).
- Same config as first test, CS released after 20 bits (0x0B then 0xABC) -> cmd 0x0B, addr 0xABC, data 0, bit_count 20, flag 3'b001. Then 70 bits sent -> bit_count 70, flag 3'b010.
- pkt_ready held low across two complete frames -> first packet held unchanged with flag[2]=1; second frame dropped; after ready, no further packet.
- HRESETn asserted mid-address with CS low, released, CS stays low 10 more edges then rises -> no packet. Next full frame captured correctly.
- cfg_cmd_len changed from 8 to 16 mid-frame -> packet uses 8. All lengths 0, 5-bit frame -> fields 0, bit_count 5, flag 3'b010.
